// File: rtl/ppe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ppe_pkg: shared constants and helpers for pending_priority_encoder     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ppe_pkg;

    localparam int PPE_CODE_NONE = 0;

    // Output code width: channel index width plus one so that 0 can mean "none".
    function automatic int ppe_code_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // One bit of the one-hot grant mask selected by a code (code = index + 1).
    function automatic logic ppe_mask_bit(input int unsigned code, input int unsigned bit_idx);
        return (code != PPE_CODE_NONE) && (code == bit_idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppe_select.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ppe_select: descending search of a request vector from a start index  |
// | with wrap from 0 to N-1. Rev 1.0                                       |
// +-----------------------------------------------------------------------+
module ppe_select #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [M-1:0] i_start,
    output logic         o_found,
    output logic [M-1:0] o_idx
);

    int w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_start) - k + N) % N;
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos[M-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pending_priority_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pending_priority_encoder: latches channel rising edges and serves them |
// | one code per valid/ready transfer. PPE_ROUND_ROBIN_EN selects rotating |
// | priority; default is fixed highest-index priority. Rev 1.0            |
// +-----------------------------------------------------------------------+
module pending_priority_encoder #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] x,
    input  logic         clr_all,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [M:0]   out_code,
    output logic [N-1:0] pending,
    output logic         overflow
);
    import ppe_pkg::*;

    localparam int CW = ppe_code_w(N);

    logic [N-1:0]  r_x_prev;
    logic [N-1:0]  r_pending;
    logic          r_valid;
    logic [CW-1:0] r_code;
    logic          r_overflow;

    logic [N-1:0]  w_edge_en;
    logic [N-1:0]  w_grant_mask;
    logic [M-1:0]  w_start;
    logic          w_found;
    logic [M-1:0]  w_idx;
    logic          w_load;
    logic          w_grant;
    logic [CW-1:0] w_grant_code;
    logic          w_ovf_set;

    assign w_edge_en    = x & ~r_x_prev & {N{en}};
    assign w_load       = !r_valid || out_ready;
    assign w_grant      = w_load && w_found;
    assign w_grant_code = w_grant ? (CW'(w_idx) + CW'(1)) : CW'(PPE_CODE_NONE);
    assign w_ovf_set    = |(w_edge_en & r_pending & ~w_grant_mask);

    always_comb begin
        w_grant_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_grant_mask[i] = ppe_mask_bit(int'(unsigned'(w_grant_code)), i);
        end
    end

`ifdef PPE_ROUND_ROBIN_EN
    // Pointer holds the next search start: one below the last grant, wrapping.
    logic [M-1:0] r_ptr;

    assign w_start = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= M'(N - 1);
        end else if (clr_all) begin
            r_ptr <= M'(N - 1);
        end else if (w_grant) begin
            r_ptr <= (w_idx == '0) ? M'(N - 1) : (w_idx - 1'b1);
        end
    end
`else
    assign w_start = M'(N - 1);
`endif

    ppe_select #(
        .N (N),
        .M (M)
    ) u_select (
        .i_req   (r_pending),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_prev   <= '0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_code     <= CW'(PPE_CODE_NONE);
            r_overflow <= 1'b0;
        end else begin
            r_x_prev <= x;
            if (clr_all) begin
                r_pending  <= '0;
                r_valid    <= 1'b0;
                r_code     <= CW'(PPE_CODE_NONE);
                r_overflow <= 1'b0;
            end else begin
                // A new edge on the channel being granted re-pends it.
                r_pending <= (r_pending & ~w_grant_mask) | w_edge_en;
                if (w_ovf_set) begin
                    r_overflow <= 1'b1;
                end
                if (w_load) begin
                    r_valid <= w_found;
                    r_code  <= w_grant_code;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pending_priority_encoder: directed table, hand sequences and random |
// | stimulus against a behavioural model. Rev 1.0                         |
// +-----------------------------------------------------------------------+
module tb_pending_priority_encoder;

    localparam int N = 16;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] x = '0;
    logic         clr_all = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [M:0]   out_code;
    logic [N-1:0] pending;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    pending_priority_encoder #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x         (x),
        .clr_all   (clr_all),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-channel flags and a one-entry slot.
    bit m_pend[N];
    bit m_xp[N];
    bit m_valid;
    int m_code;
    bit m_ovf;
    int m_ptr;

    typedef struct {
        logic [N-1:0] vx;
        logic         rdy;
        logic         ev;
        int           ec;
        logic [N-1:0] ep;
        logic         eo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_xp[i]   = 1'b0;
        end
        m_valid = 1'b0;
        m_code  = 0;
        m_ovf   = 1'b0;
        m_ptr   = N - 1;
    endtask

    task automatic model_step();
        int  sel;
        int  start;
        int  ch;
        bit  load;
        bit  e;
        sel  = -1;
        load = !m_valid || out_ready;
`ifdef PPE_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = N - 1;
`endif
        if (load) begin
            for (int k = 0; k < N; k++) begin
                ch = (start - k + N) % N;
                if (sel < 0 && m_pend[ch]) sel = ch;
            end
        end
        if (clr_all) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 0;
            m_ovf   = 1'b0;
            m_ptr   = N - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                e = x[i] && !m_xp[i] && en;
                if (e && m_pend[i] && i != sel) m_ovf = 1'b1;
                m_pend[i] = (m_pend[i] && i != sel) || e;
            end
            if (load) begin
                m_valid = (sel >= 0);
                m_code  = sel + 1;
                if (sel >= 0) m_ptr = (sel + N - 1) % N;
            end
        end
        for (int i = 0; i < N; i++) m_xp[i] = x[i];
    endtask

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_valid",    64'(out_valid), 64'(m_valid));
        check("model_code",     64'(out_code),  64'(m_code));
        check("model_pending",  64'(pending),   64'(model_pend_vec()));
        check("model_overflow", 64'(overflow),  64'(m_ovf));
    endtask

    function automatic vec_t mk(input logic [N-1:0] vx, input logic rdy, input logic ev,
                                input int ec, input logic [N-1:0] ep, input logic eo);
        vec_t v;
        v.vx = vx; v.rdy = rdy; v.ev = ev; v.ec = ec; v.ep = ep; v.eo = eo;
        return v;
    endfunction

    initial begin
        // Single edge on x[5], then three simultaneous edges, then a re-edge of 15 and 9.
        vecs.push_back(mk(16'h0020, 1, 0,  0, 16'h0020, 0));
        vecs.push_back(mk(16'h0020, 1, 1,  6, 16'h0000, 0));
        vecs.push_back(mk(16'h0020, 1, 0,  0, 16'h0000, 0));
        vecs.push_back(mk(16'h0000, 1, 0,  0, 16'h0000, 0));
        vecs.push_back(mk(16'h8208, 1, 0,  0, 16'h8208, 0));
        vecs.push_back(mk(16'h8208, 1, 1, 16, 16'h0208, 0));
        vecs.push_back(mk(16'h0000, 1, 1, 10, 16'h0008, 0));
        vecs.push_back(mk(16'h0000, 1, 1,  4, 16'h0000, 0));
        vecs.push_back(mk(16'h0000, 1, 0,  0, 16'h0000, 0));
        vecs.push_back(mk(16'h8200, 1, 0,  0, 16'h8200, 0));
        vecs.push_back(mk(16'h8200, 1, 1, 16, 16'h0200, 0));
        vecs.push_back(mk(16'h0000, 1, 1, 10, 16'h0000, 0));
        vecs.push_back(mk(16'h0000, 1, 0,  0, 16'h0000, 0));

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid",    64'(out_valid), 64'(0));
        check("reset_code",     64'(out_code),  64'(0));
        check("reset_pending",  64'(pending),   64'(0));
        check("reset_overflow", 64'(overflow),  64'(0));
        rst = 1'b0;
        tick();

        foreach (vecs[j]) begin
            x         = vecs[j].vx;
            out_ready = vecs[j].rdy;
            tick();
            check($sformatf("vec%0d_valid", j),    64'(out_valid), 64'(vecs[j].ev));
            check($sformatf("vec%0d_code", j),     64'(out_code),  64'(vecs[j].ec));
            check($sformatf("vec%0d_pending", j),  64'(pending),   64'(vecs[j].ep));
            check($sformatf("vec%0d_overflow", j), 64'(overflow),  64'(vecs[j].eo));
        end

        // Held slot with repeated edges on x[2].
        out_ready = 1'b0;
        x = 16'h0004; tick();
        x = 16'h0004; tick();
        check("hold_code3", 64'(out_code), 64'(3));
        x = 16'h0000; tick();
        x = 16'h0004; tick();
        check("repend_code", 64'(out_code), 64'(3));
        check("repend_pending", 64'(pending), 64'(16'h0004));
        check("repend_no_ovf", 64'(overflow), 64'(0));
        x = 16'h0000; tick();
        x = 16'h0004; tick();
        check("third_rise_ovf", 64'(overflow), 64'(1));
        check("third_rise_code", 64'(out_code), 64'(3));

        // Build pending=0x0110 behind a full slot, then clr_all with x[1] rising.
        out_ready = 1'b1;
        x = 16'h0000; repeat (3) tick();
        out_ready = 1'b0;
        x = 16'h0400; tick();
        tick();
        x = 16'h0510; tick();
        check("preclr_pending", 64'(pending), 64'(16'h0110));
        check("preclr_ovf", 64'(overflow), 64'(1));
        clr_all = 1'b1;
        x = 16'h0512; tick();
        clr_all = 1'b0;
        check("clr_pending", 64'(pending), 64'(0));
        check("clr_valid", 64'(out_valid), 64'(0));
        check("clr_ovf", 64'(overflow), 64'(0));
        tick();
        check("clr_x1_dropped", 64'(pending), 64'(0));

        // en low masks capture; a level already high later is not an edge.
        out_ready = 1'b1;
        x = 16'h0000; tick();
        en = 1'b0;
        x = 16'h0080; tick(); tick();
        check("en0_pending", 64'(pending), 64'(0));
        check("en0_valid", 64'(out_valid), 64'(0));
        en = 1'b1; tick(); tick();
        check("en1_no_edge_pending", 64'(pending), 64'(0));
        check("en1_no_edge_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset mid-stream, release with x[0] high.
        x = 16'h0000; tick();
        x = 16'h0003; tick();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_code", 64'(out_code), 64'(0));
        check("arst_pending", 64'(pending), 64'(0));
        check("arst_ovf", 64'(overflow), 64'(0));
        x = 16'h0001;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        check("post_rst_pending", 64'(pending), 64'(16'h0001));
        tick();
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_code", 64'(out_code), 64'(1));

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            x         = x ^ (N'($urandom) & N'($urandom));
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_all   = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr_all = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        repeat (N + 2) tick();
        check("drain_empty", 64'(pending), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
